// File: rtl/shift_reg_pkg.sv
// Mode encodings shared by the shift register bank and its stages.
// Width/depth-derived constants stay inside the modules that own the parameters.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_CLEAR = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/shift_register_bank_d_stage.sv
// d_stage: one WIDTH-bit edge-triggered register of the bank.
// Synchronous clear has priority; when enabled, the next value is either the
// shift-in word from the previous stage or this stage's parallel-load slice.
module d_stage #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             clr,
    input  logic             en,
    input  logic             sel_load,
    input  logic [WIDTH-1:0] shift_in,
    input  logic [WIDTH-1:0] load_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;

    // Choose between shift-in and parallel-load data for the next value.
    always_comb begin
        next_s = shift_in;
        if (sel_load) begin
            next_s = load_in;
        end else begin
            next_s = shift_in;
        end
    end

    // Stage register: clear wins, otherwise capture when enabled, else hold.
    always_ff @(posedge Clock) begin
        if (clr) begin
            q_r <= {WIDTH{1'b0}};
        end else if (en) begin
            q_r <= next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/shift_register_bank.sv
// shift_register_bank: DEPTH-stage, WIDTH-bit register chain with
// hold / shift / parallel-load / clear modes and saturating occupancy count.
// Optional feature: define SHIFT_REG_ROTATE_EN to add the 'rot' input, which
// turns a SHIFT into a rotation (oldest stage feeds stage 0, count untouched).
// Stage 0 sits in the low slice of q_all/load_data; q is the oldest stage.
module shift_register_bank
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       d,
    input  logic [WIDTH*DEPTH-1:0] load_data,
`ifdef SHIFT_REG_ROTATE_EN
    input  logic                   rot,
`endif
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH*DEPTH-1:0] q_all,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    shift_mode_t      mode_s;
    logic             clear_s;
    logic             stage_en_s;
    logic             sel_load_s;
    logic             rotate_s;
    logic [WIDTH-1:0] stage0_in_s;
    logic [WIDTH-1:0] stage_s [DEPTH];

    logic [CNT_W-1:0] count_next_s;
    logic             overflow_next_s;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;

    assign mode_s = shift_mode_t'(mode);

    // Decode the requested mode into stage controls; Reset overrides any mode.
    always_comb begin
        clear_s    = 1'b0;
        stage_en_s = 1'b0;
        sel_load_s = 1'b0;
        rotate_s   = 1'b0;
        if (Reset) begin
            clear_s = 1'b1;
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    stage_en_s = 1'b0;
                end
                MODE_SHIFT: begin
                    stage_en_s = 1'b1;
`ifdef SHIFT_REG_ROTATE_EN
                    rotate_s   = rot;
`else
                    rotate_s   = 1'b0;
`endif
                end
                MODE_LOAD: begin
                    stage_en_s = 1'b1;
                    sel_load_s = 1'b1;
                end
                MODE_CLEAR: begin
                    clear_s = 1'b1;
                end
                default: begin
                    clear_s = 1'b1;
                end
            endcase
        end
    end

    // Stage 0 shift-in source: serial input, or the oldest stage when rotating.
    always_comb begin
        stage0_in_s = d;
        if (rotate_s) begin
            stage0_in_s = stage_s[DEPTH-1];
        end else begin
            stage0_in_s = d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] shift_src_s;
            if (gi == 0) begin : g_head
                assign shift_src_s = stage0_in_s;
            end else begin : g_body
                assign shift_src_s = stage_s[gi-1];
            end

            d_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .Clock    (Clock),
                .clr      (clear_s),
                .en       (stage_en_s),
                .sel_load (sel_load_s),
                .shift_in (shift_src_s),
                .load_in  (load_data[gi*WIDTH +: WIDTH]),
                .q        (stage_s[gi])
            );

            assign q_all[gi*WIDTH +: WIDTH] = stage_s[gi];
        end
    endgenerate

    // Next occupancy and overflow: load fills, shift counts up or drops the
    // oldest entry when already full, rotation leaves occupancy alone.
    always_comb begin
        count_next_s    = count_r;
        overflow_next_s = 1'b0;
        if (clear_s) begin
            count_next_s = CNT_ZERO;
        end else if (stage_en_s && sel_load_s) begin
            count_next_s = CNT_FULL;
        end else if (stage_en_s && !rotate_s) begin
            if (count_r == CNT_FULL) begin
                count_next_s    = CNT_FULL;
                overflow_next_s = 1'b1;
            end else begin
                count_next_s = count_r + CNT_ONE;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Occupancy registers; full/empty are registered from the next count so
    // every status output comes straight from a flop.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_r    <= CNT_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CNT_FULL);
            empty_r    <= (count_next_s == CNT_ZERO);
            overflow_r <= overflow_next_s;
        end
    end

    assign q        = stage_s[DEPTH-1];
    assign count    = count_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_shift_register_bank.sv
// Directed, table-driven bench for shift_register_bank (WIDTH=8, DEPTH=4).
// Each vector is applied for one clock edge and all outputs are compared 1ns later.
module tb_shift_register_bank;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic                   Clock;
    logic                   Reset;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       d;
    logic [WIDTH*DEPTH-1:0] load_data;
    logic                   rot;
    logic [WIDTH-1:0]       q;
    logic [WIDTH*DEPTH-1:0] q_all;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   empty;
    logic                   overflow;

    int n_checks = 0;
    int n_errors = 0;

    shift_register_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .mode      (mode),
        .d         (d),
        .load_data (load_data),
`ifdef SHIFT_REG_ROTATE_EN
        .rot       (rot),
`endif
        .q         (q),
        .q_all     (q_all),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        rst;
        logic [1:0]  md;
        logic [7:0]  din;
        logic [31:0] ld;
        logic        rt;
        logic [7:0]  eq;
        logic [31:0] eq_all;
        logic [2:0]  ecnt;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    localparam logic [1:0] H = 2'b00;
    localparam logic [1:0] S = 2'b01;
    localparam logic [1:0] L = 2'b10;
    localparam logic [1:0] C = 2'b11;

    task automatic add(input logic r, input logic [1:0] m, input logic [7:0] di,
                       input logic [31:0] l, input logic rt, input logic [31:0] eall,
                       input logic [2:0] ec, input logic eo);
        vec_t v;
        v.rst = r; v.md = m; v.din = di; v.ld = l; v.rt = rt;
        v.eq_all = eall; v.eq = eall[31:24]; v.ecnt = ec; v.eovf = eo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] m, input logic [7:0] di,
                        input logic [31:0] l, input logic rt);
        Reset = r; mode = m; d = di; load_data = l; rot = rt;
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] eall,
                             input logic [2:0] ec, input logic eo);
        check({tag, " q"},        {24'h000000, q}, {24'h000000, eall[31:24]});
        check({tag, " q_all"},    q_all, eall);
        check({tag, " count"},    {29'd0, count}, {29'd0, ec});
        check({tag, " full"},     {31'd0, full},  {31'd0, (ec == 3'd4)});
        check({tag, " empty"},    {31'd0, empty}, {31'd0, (ec == 3'd0)});
        check({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
        check({tag, " full_and_empty"}, {31'd0, (full & empty)}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1; mode = H; d = 8'h00; load_data = 32'h0; rot = 1'b0;

        //   rst  mode din    load_data     rot  q_all          cnt   ovf
        add(1'b1, H, 8'h00, 32'h00000000, 1'b0, 32'h00000000, 3'd0, 1'b0);
        add(1'b1, H, 8'h00, 32'h00000000, 1'b0, 32'h00000000, 3'd0, 1'b0);
        add(1'b0, S, 8'h11, 32'h00000000, 1'b0, 32'h00000011, 3'd1, 1'b0);
        add(1'b0, S, 8'h22, 32'h00000000, 1'b0, 32'h00001122, 3'd2, 1'b0);
        add(1'b0, S, 8'h33, 32'h00000000, 1'b0, 32'h00112233, 3'd3, 1'b0);
        add(1'b0, S, 8'h44, 32'h00000000, 1'b0, 32'h11223344, 3'd4, 1'b0);
        add(1'b0, S, 8'h55, 32'h00000000, 1'b0, 32'h22334455, 3'd4, 1'b1);
        add(1'b0, H, 8'h99, 32'h00000000, 1'b0, 32'h22334455, 3'd4, 1'b0);
        add(1'b0, L, 8'h00, 32'hA1B2C3D4, 1'b0, 32'hA1B2C3D4, 3'd4, 1'b0);
        add(1'b0, S, 8'h66, 32'h00000000, 1'b0, 32'hB2C3D466, 3'd4, 1'b1);
        add(1'b0, C, 8'h77, 32'hFFFFFFFF, 1'b0, 32'h00000000, 3'd0, 1'b0);
        add(1'b0, S, 8'h77, 32'h00000000, 1'b0, 32'h00000077, 3'd1, 1'b0);
        add(1'b0, S, 8'h88, 32'h00000000, 1'b0, 32'h00007788, 3'd2, 1'b0);
        add(1'b1, L, 8'h00, 32'hFFFFFFFF, 1'b0, 32'h00000000, 3'd0, 1'b0);
        add(1'b0, H, 8'h5A, 32'hFFFFFFFF, 1'b0, 32'h00000000, 3'd0, 1'b0);
        add(1'b0, L, 8'h00, 32'h01020304, 1'b0, 32'h01020304, 3'd4, 1'b0);
        add(1'b0, H, 8'h99, 32'hFFFFFFFF, 1'b0, 32'h01020304, 3'd4, 1'b0);
`ifdef SHIFT_REG_ROTATE_EN
        add(1'b0, S, 8'hEE, 32'h00000000, 1'b1, 32'h02030401, 3'd4, 1'b0);
        add(1'b0, S, 8'hEE, 32'h00000000, 1'b1, 32'h03040102, 3'd4, 1'b0);
        add(1'b0, S, 8'hEE, 32'h00000000, 1'b1, 32'h04010203, 3'd4, 1'b0);
        add(1'b0, S, 8'hEE, 32'h00000000, 1'b1, 32'h01020304, 3'd4, 1'b0);
        add(1'b0, H, 8'hEE, 32'h00000000, 1'b1, 32'h01020304, 3'd4, 1'b0);
        add(1'b0, L, 8'h00, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 3'd4, 1'b0);
`else
        add(1'b0, S, 8'hEE, 32'h00000000, 1'b1, 32'h020304EE, 3'd4, 1'b1);
`endif

        @(negedge Clock);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].md, vecs[i].din, vecs[i].ld, vecs[i].rt);
            check_all($sformatf("vec%0d", i), vecs[i].eq_all, vecs[i].ecnt, vecs[i].eovf);
        end

        // Latency with HOLD stalls: a word shifted in reaches q after DEPTH-1
        // further shifts, regardless of HOLD cycles in between.
        step(1'b0, C, 8'h00, 32'h0, 1'b0);
        step(1'b0, S, 8'hAB, 32'h0, 1'b0);
        step(1'b0, H, 8'hFF, 32'h0, 1'b0);
        step(1'b0, H, 8'hFF, 32'h0, 1'b0);
        check_all("lat_hold", 32'h000000AB, 3'd1, 1'b0);
        step(1'b0, S, 8'h01, 32'h0, 1'b0);
        step(1'b0, S, 8'h02, 32'h0, 1'b0);
        check_all("lat_pre", 32'h00AB0102, 3'd3, 1'b0);
        step(1'b0, S, 8'h03, 32'h0, 1'b0);
        check_all("lat_out", 32'hAB010203, 3'd4, 1'b0);

        // Back-to-back shifts while full: overflow stays high on each, count saturates.
        step(1'b0, S, 8'h04, 32'h0, 1'b0);
        check_all("ovf_a", 32'h01020304, 3'd4, 1'b1);
        step(1'b0, S, 8'h05, 32'h0, 1'b0);
        check_all("ovf_b", 32'h02030405, 3'd4, 1'b1);
        step(1'b0, L, 8'h00, 32'h10203040, 1'b0);
        check_all("ovf_load", 32'h10203040, 3'd4, 1'b0);

        // Reset in the middle of a shift sequence.
        step(1'b0, C, 8'h00, 32'h0, 1'b0);
        step(1'b0, S, 8'hC1, 32'h0, 1'b0);
        step(1'b1, S, 8'hC2, 32'h0, 1'b0);
        check_all("rst_mid", 32'h00000000, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
